alu_op_issue_stage: RTL and testbench



---
 rtl/alu_op_issue_stage.sv | 140 ++++++++++++++
 tb/tb_alu_op_issue_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issue_stage.sv
// ALU op issue stage: registered opcode decode with valid/ready flow control,
// illegal-opcode accounting and back-pressure while a multi-cycle op runs.
module alu_op_issue_stage #(
   parameter int OP_W    = 5,
   parameter int CTRL_W  = 3,
   parameter int MUL_LAT = 3,
   parameter int MOD_LAT = 4,
   parameter int ICNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] alu_ctrl,
   output logic              illegal,
   output logic              busy,
   output logic [ICNT_W-1:0] illegal_cnt
);

   localparam int LMAX = (MUL_LAT > MOD_LAT) ? MUL_LAT : MOD_LAT;
   localparam int CW   = $clog2(LMAX + 1);

   localparam logic [4:0] OP_ADD = 5'b11000;
   localparam logic [4:0] OP_SUB = 5'b11010;
   localparam logic [4:0] OP_MUL = 5'b11110;
   localparam logic [4:0] OP_MOD = 5'b11100;
   localparam logic [4:0] OP_LSR = 5'b11001;
   localparam logic [4:0] OP_MOV = 5'b10100;

   typedef enum logic {RUN, STALL} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic              is_mul;
   logic              is_mod;

   logic [CTRL_W-1:0] dec_ctrl;
   logic              dec_ill;
   logic              dec_mul;
   logic              dec_mod;
   logic              hi_zero;
   logic              retire;
   logic              multi_ret;
   logic              accept;

   assign hi_zero = ((in_op >> 5) == '0);

   always_comb begin
      dec_ctrl = '1;
      dec_ill  = 1'b1;
      dec_mul  = 1'b0;
      dec_mod  = 1'b0;
      unique case (1'b1)
         (hi_zero && in_op[4:0] == OP_ADD): begin
            dec_ctrl = CTRL_W'(0);
            dec_ill  = 1'b0;
         end
         (hi_zero && in_op[4:0] == OP_SUB): begin
            dec_ctrl = CTRL_W'(1);
            dec_ill  = 1'b0;
         end
         (hi_zero && in_op[4:0] == OP_MUL): begin
            dec_ctrl = CTRL_W'(2);
            dec_ill  = 1'b0;
            dec_mul  = 1'b1;
         end
         (hi_zero && in_op[4:0] == OP_MOD): begin
            dec_ctrl = CTRL_W'(3);
            dec_ill  = 1'b0;
            dec_mod  = 1'b1;
         end
         (hi_zero && in_op[4:0] == OP_LSR): begin
            dec_ctrl = CTRL_W'(4);
            dec_ill  = 1'b0;
         end
         (hi_zero && in_op[4:0] == OP_MOV): begin
            dec_ctrl = CTRL_W'(5);
            dec_ill  = 1'b0;
         end
         default: ;
      endcase
   end

   // A retiring multi-cycle op blocks the slot it would otherwise free.
   assign retire    = out_valid & out_ready;
   assign multi_ret = retire &
                      ((is_mul & (MUL_LAT > 1)) | (is_mod & (MOD_LAT > 1)));
   assign in_ready  = (state == RUN) & ~flush &
                      (~out_valid | (out_ready & ~multi_ret));
   assign accept    = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         alu_ctrl    <= '1;
         illegal     <= 1'b0;
         is_mul      <= 1'b0;
         is_mod      <= 1'b0;
         busy        <= 1'b0;
         illegal_cnt <= '0;
         cnt         <= '0;
         state       <= RUN;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            alu_ctrl  <= dec_ctrl;
            illegal   <= dec_ill;
            is_mul    <= dec_mul;
            is_mod    <= dec_mod;
            if (dec_ill && illegal_cnt != '1)
               illegal_cnt <= illegal_cnt + ICNT_W'(1);
         end else if (retire || flush) begin
            out_valid <= 1'b0;
         end

         if (flush) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b0;
         end else if (multi_ret) begin
            state <= STALL;
            busy  <= 1'b1;
            cnt   <= is_mul ? CW'(MUL_LAT - 1) : CW'(MOD_LAT - 1);
         end else if (state == STALL) begin
            if (cnt == CW'(1)) begin
               state <= RUN;
               busy  <= 1'b0;
               cnt   <= '0;
            end else begin
               cnt <= cnt - CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_op_issue_stage.sv
// Directed bench for alu_op_issue_stage: decode, hold, stall, flush,
// illegal saturation and asynchronous reset.
module tb_alu_op_issue_stage;

   localparam int OP_W = 6;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [OP_W-1:0] in_op;
   logic            out_valid;
   logic            out_ready;
   logic [2:0]      alu_ctrl;
   logic            illegal;
   logic            busy;
   logic [1:0]      illegal_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   alu_op_issue_stage #(
      .OP_W(OP_W), .CTRL_W(3), .MUL_LAT(3), .MOD_LAT(4), .ICNT_W(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_ctrl(alu_ctrl), .illegal(illegal), .busy(busy),
      .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [OP_W-1:0] op);
      in_valid = v;
      in_op    = op;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
      in_op = '0; out_ready = 1'b1;
      #12;
      check("rst out_valid", out_valid, 0);
      check("rst alu_ctrl", alu_ctrl, 3'b111);
      check("rst illegal", illegal, 0);
      check("rst busy", busy, 0);
      check("rst icnt", illegal_cnt, 0);
      rst_n = 1'b1;
      tick();

      // back-to-back single-cycle ops
      drive(1, 6'b011000);
      check("add in_ready", in_ready, 1);
      tick();
      check("add valid", out_valid, 1);
      check("add ctrl", alu_ctrl, 3'b000);
      drive(1, 6'b011010);
      check("sub in_ready", in_ready, 1);
      tick();
      check("sub ctrl", alu_ctrl, 3'b001);
      drive(1, 6'b010100);
      check("mov in_ready", in_ready, 1);
      tick();
      check("mov ctrl", alu_ctrl, 3'b101);
      check("mov illegal", illegal, 0);
      drive(0, '0);
      tick();
      check("drain valid", out_valid, 0);

      // hold under back-pressure
      out_ready = 1'b0;
      drive(1, 6'b011001);
      tick();
      check("lsr ctrl", alu_ctrl, 3'b100);
      drive(1, 6'b011000);
      for (int i = 0; i < 3; i++) begin
         check("hold ready", in_ready, 0);
         tick();
         check("hold ctrl", alu_ctrl, 3'b100);
         check("hold valid", out_valid, 1);
      end
      out_ready = 1'b1;
      #1;
      check("release ready", in_ready, 1);
      tick();
      check("next ctrl", alu_ctrl, 3'b000);
      check("next valid", out_valid, 1);
      drive(0, '0);
      tick();

      // MUL stall
      drive(1, 6'b011110);
      tick();
      check("mul ctrl", alu_ctrl, 3'b010);
      drive(1, 6'b011000);
      check("mul ret ready", in_ready, 0);
      tick();
      check("stall1 busy", busy, 1);
      check("stall1 ready", in_ready, 0);
      check("stall1 valid", out_valid, 0);
      tick();
      check("stall2 busy", busy, 1);
      check("stall2 ready", in_ready, 0);
      tick();
      check("stall end busy", busy, 0);
      check("stall end ready", in_ready, 1);
      tick();
      check("post mul valid", out_valid, 1);
      check("post mul ctrl", alu_ctrl, 3'b000);
      drive(0, '0);
      tick();

      // illegal opcodes and saturation
      drive(1, 6'b000000);
      tick();
      check("ill0 ctrl", alu_ctrl, 3'b111);
      check("ill0 flag", illegal, 1);
      drive(1, 6'b111000);
      tick();
      check("ill1 flag", illegal, 1);
      check("ill1 ctrl", alu_ctrl, 3'b111);
      check("icnt 2", illegal_cnt, 2);
      drive(1, 6'b010101);
      tick();
      check("icnt 3", illegal_cnt, 3);
      drive(1, 6'b111111);
      tick();
      drive(1, 6'b000001);
      tick();
      check("icnt sat", illegal_cnt, 3);
      drive(1, 6'b011010);
      tick();
      check("legal after ill", illegal, 0);
      check("legal ctrl", alu_ctrl, 3'b001);
      drive(0, '0);
      tick();

      // flush aborts a modulo stall
      drive(1, 6'b011100);
      tick();
      check("mod ctrl", alu_ctrl, 3'b011);
      drive(0, '0);
      tick();
      check("mod stall1", busy, 1);
      tick();
      check("mod stall2", busy, 1);
      flush = 1'b1;
      #1;
      check("flush ready", in_ready, 0);
      tick();
      check("flush busy", busy, 0);
      flush = 1'b0;
      #1;
      check("after flush ready", in_ready, 1);
      check("flush icnt", illegal_cnt, 3);

      // MUL retire coinciding with flush: no stall
      drive(1, 6'b011110);
      tick();
      drive(0, '0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      check("flush ret busy", busy, 0);
      check("flush ret valid", out_valid, 0);
      check("flush ret ready", in_ready, 1);

      // async reset mid-STALL
      drive(1, 6'b011110);
      tick();
      drive(0, '0);
      tick();
      check("pre rst busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("rst stall busy", busy, 0);
      check("rst stall valid", out_valid, 0);
      check("rst stall ctrl", alu_ctrl, 3'b111);
      check("rst stall icnt", illegal_cnt, 0);
      rst_n = 1'b1;
      tick();

      // async reset mid-hold
      out_ready = 1'b0;
      drive(1, 6'b011001);
      tick();
      drive(0, '0);
      check("pre rst hold", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("rst hold valid", out_valid, 0);
      check("rst hold ctrl", alu_ctrl, 3'b111);
      check("rst hold busy", busy, 0);
      rst_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
